// File: rtl/shift_register_piso.sv
// Parallel-in, serial-out shifter with a valid/ready load port.
// Words go out one bit per clock, and the next word can load on the last bit's edge so there is no idle cycle.
module shift_register_piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadValid,
    input  logic [WIDTH-1:0] LoadData,
    output logic             LoadReady,
    output logic             ShiftOut,
    output logic             ShiftValid,
    output logic             Busy,
    output logic             Done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [CW-1:0]    cnt_r;
    logic             shifting_s;
    logic             last_s;
    logic             load_ready_s;
    logic             load_s;

    // The bit on ShiftOut always sits at the outgoing end, so one step moves the next bit into place.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Output decode from registered state only; LoadReady is gated low while Reset is held.
    always_comb begin
        shifting_s = (state_r == ST_SHIFT);
        last_s     = shifting_s && (cnt_r == CNT_ZERO);
        if (Reset) begin
            load_ready_s = 1'b0;
        end else if (!shifting_s || (cnt_r == CNT_ZERO)) begin
            load_ready_s = 1'b1;
        end else begin
            load_ready_s = 1'b0;
        end
        load_s     = LoadValid && load_ready_s;
        LoadReady  = load_ready_s;
        ShiftValid = shifting_s;
        Busy       = shifting_s;
        Done       = last_s;
        if (shifting_s) begin
            ShiftOut = MSB_FIRST ? shreg_r[WIDTH-1] : shreg_r[0];
        end else begin
            ShiftOut = 1'b0;
        end
    end

    // Load/shift state machine; loading on the last bit keeps the stream contiguous.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        shreg_r <= LoadData;
                        cnt_r   <= CNT_LAST;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r != CNT_ZERO) begin
                        shreg_r <= shift_once(shreg_r);
                        cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end else if (load_s) begin
                        shreg_r <= LoadData;
                        cnt_r   <= CNT_LAST;
                        state_r <= ST_SHIFT;
                    end else begin
                        shreg_r <= {WIDTH{1'b0}};
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    shreg_r <= {WIDTH{1'b0}};
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_piso.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share stimulus.
// Each accepted word queues its expected bit stream; a monitor pops one entry per cycle and checks the serial outputs and a loopback SIPO.
module tb_shift_register_piso;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [3:0] load_data;
    logic [1:0] rdy, so, sv, busy, done;
    logic [3:0] sipo = 4'b0000;

    typedef struct {
        logic       bm;
        logic       bl;
        logic       last;
        logic [3:0] word;
    } item_t;

    item_t      q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       pend     = 1'b0;
    logic [3:0] pend_word;

    shift_register_piso #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .Clk(clk), .Reset(rst), .LoadValid(load_valid), .LoadData(load_data),
        .LoadReady(rdy[0]), .ShiftOut(so[0]), .ShiftValid(sv[0]), .Busy(busy[0]), .Done(done[0]));

    shift_register_piso #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .Clk(clk), .Reset(rst), .LoadValid(load_valid), .LoadData(load_data),
        .LoadReady(rdy[1]), .ShiftOut(so[1]), .ShiftValid(sv[1]), .Busy(busy[1]), .Done(done[1]));

    always #5 clk = ~clk;

    // Downstream receiver: shifts in at bit 0 whenever the MSB-first stream is valid.
    always @(posedge clk) begin
        if (sv[0]) sipo <= {sipo[2:0], so[0]};
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per cycle while bits are owed, otherwise outputs must be quiet.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (pend) begin
                check("sipo_word", {4'b0000, sipo}, {4'b0000, pend_word});
                pend = 1'b0;
            end
            if (q.size() > 0) begin
                it = q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("valid[%0d]", d), {7'd0, sv[d]}, 8'd1);
                    check($sformatf("busy[%0d]", d), {7'd0, busy[d]}, 8'd1);
                    check($sformatf("done[%0d]", d), {7'd0, done[d]}, {7'd0, it.last});
                end
                check("bit_msb", {7'd0, so[0]}, {7'd0, it.bm});
                check("bit_lsb", {7'd0, so[1]}, {7'd0, it.bl});
                if (it.last) begin
                    pend      = 1'b1;
                    pend_word = it.word;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("idle_outs[%0d]", d),
                          {4'd0, sv[d], busy[d], done[d], so[d]}, 8'd0);
                end
            end
        end
    end

    task automatic check_ready();
        logic exp_rdy;
        exp_rdy = !rst && (q.size() == 0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("ready[%0d]", d), {7'd0, rdy[d]}, {7'd0, exp_rdy});
        end
    endtask

    task automatic push_word(input logic [3:0] w);
        item_t it;
        for (int i = 0; i < 4; i++) begin
            it.bm   = w[3-i];
            it.bl   = w[i];
            it.last = (i == 3);
            it.word = w;
            q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #2;
            check_ready();
            load_valid = 1'b0;
            load_data  = 4'($urandom);
        end
    endtask

    // Hold LoadValid with the word until the model says it is accepted.
    task automatic send(input logic [3:0] w);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 12 && !acc; t++) begin
            @(negedge clk); #2;
            check_ready();
            load_valid = 1'b1;
            load_data  = w;
            if (!rst && q.size() == 0) begin
                push_word(w);
                acc = 1'b1;
            end
        end
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept of %0h", w);
        end
    endtask

    task automatic apply_reset(input int ncyc);
        rst        = 1'b1;
        load_valid = 1'b1;
        q.delete();
        pend = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_outs[%0d]", d),
                  {3'd0, rdy[d], sv[d], busy[d], done[d], so[d]}, 8'd0);
        end
        repeat (ncyc) begin
            @(negedge clk); #2;
            check_ready();
        end
        rst        = 1'b0;
        load_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'b1010;
        apply_reset(2);
        send(4'b1011);
        idle(6);
        send(4'b1011);
        send(4'b0110);
        idle(6);
        send(4'b1100);
        send(4'b0001);
        idle(6);
        send(4'b1111);
        idle(2);
        apply_reset(1);
        send(4'b0101);
        idle(6);
        send(4'b1001);
        idle(6);
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                idle($urandom_range(0, 3));
                apply_reset($urandom_range(1, 2));
            end else if (r < 5) begin
                idle($urandom_range(1, 5));
            end else begin
                send(4'($urandom));
            end
        end
        idle(6);
        check("drain", 8'(q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
